// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: registered command front-end for an 8-bit combinational ALU.
// Buffers {a, b, sel, acc} commands in a DEPTH-entry FIFO. It issues one command
// at a time to the ALU, registers the result, carry and divide-by-zero flag, and
// returns them on a valid/ready response port. When acc=1, A is replaced by the
// previous result.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake; cmd_a, cmd_b, cmd_sel, cmd_acc payload
//   alu_a/alu_b/alu_sel       operand and opcode lines to the ALU
//   alu_out/alu_carry         result and carry from the ALU
//   rsp_valid/rsp_ready       response handshake; rsp_data, rsp_carry, rsp_divz payload
//   fifo_count                number of commands currently buffered
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  input  logic [3:0]    cmd_sel,
  input  logic          cmd_acc,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [3:0]    alu_sel,
  input  logic [7:0]    alu_out,
  input  logic          alu_carry,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_data,
  output logic          rsp_carry,
  output logic          rsp_divz,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  logic [20:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    op_a;
  logic [7:0]    op_b;
  logic [3:0]    op_sel;
  logic [7:0]    acc_reg;
  logic          push;
  logic          pop;
  logic [20:0]   head;
  logic          divz;
  logic [7:0]    result;

  assign cmd_ready = (fifo_count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  // A new command can be issued from IDLE, or from RESP in the same edge
  // that hands the previous response over.
  assign pop       = (fifo_count != '0) &&
                     ((state == IDLE) || ((state == RESP) && rsp_ready));
  assign head      = mem[rd_ptr];

  assign divz      = (op_sel == 4'b0011) && (op_b == 8'h00);
  assign result    = divz ? 8'hFF : alu_out;

  assign alu_a     = op_a;
  assign alu_b     = op_b;
  assign alu_sel   = op_sel;

  // FIFO storage is not reset; the pointers and the count define its contents.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_sel, cmd_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      acc_reg    <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_carry  <= 1'b0;
      rsp_divz   <= 1'b0;
      state      <= IDLE;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        // acc_reg already holds the previous result when popping from RESP.
        op_a   <= head[0] ? acc_reg : head[20:13];
        op_b   <= head[12:5];
        op_sel <= head[4:1];
      end

      if (push && !pop) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop && !push) begin
        fifo_count <= fifo_count - CW'(1);
      end

      case (state)
        IDLE: begin
          if (pop) begin
            state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= result;
          rsp_carry <= alu_carry && (op_sel == 4'b0000);
          rsp_divz  <= divz;
          acc_reg   <= result;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= pop ? EXEC : IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: a behavioural ALU closes the loop, table-driven
// single-command vectors, hand sequences for back-pressure, chaining and reset,
// and a randomized run checked against a queue-based reference model.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [3:0] cmd_sel;
  logic       cmd_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_divz;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_acc(cmd_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_divz(rsp_divz),
    .fifo_count(fifo_count)
  );

  // Behavioural 8-bit ALU: returns {carry, out}; carry is the add carry for every opcode.
  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s);
    logic [8:0] sum;
    logic [7:0] r;
    sum = {1'b0, a} + {1'b0, b};
    case (s)
      4'h0: r = sum[7:0];
      4'h1: r = a - b;
      4'h2: r = 8'(a * b);
      4'h3: r = (b == 8'h00) ? 8'h00 : a / b;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = {a[6:0], a[7]};
      4'h7: r = {a[0], a[7:1]};
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? 8'd1 : 8'd0;
      default: r = (a == b) ? 8'd1 : 8'd0;
    endcase
    return {sum[8], r};
  endfunction

  always_comb begin
    {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected {data, carry, divz} for a command given the previous result.
  logic [7:0] model_acc;
  function automatic logic [9:0] model_rsp(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] s, input logic acc,
                                           input logic [7:0] prev);
    logic [8:0] r;
    logic [7:0] opa;
    logic dz;
    opa = acc ? prev : a;
    r   = alu_model(opa, b, s);
    dz  = (s == 4'h3) && (b == 8'h00);
    return {(dz ? 8'hFF : r[7:0]), (r[8] && (s == 4'h0)), dz};
  endfunction

  logic [9:0] exp_q[$];
  bit mon_en = 1'b0;
  bit rand_ready = 1'b0;

  // Response monitor: at the negedge, a valid&&ready pair will be accepted at the next posedge.
  bit stalled = 1'b0;
  logic [9:0] held;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled)
        check("stall_hold", 32'({rsp_valid, rsp_data, rsp_carry, rsp_divz}), 32'({1'b1, held}));
      if (mon_en && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else check("rsp", 32'({rsp_data, rsp_carry, rsp_divz}), 32'(exp_q.pop_front()));
      end
      stalled = rsp_valid && !rsp_ready;
      held    = {rsp_data, rsp_carry, rsp_divz};
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                          input logic acc, input logic [9:0] exp);
    bit done;
    bit rdy;
    exp_q.push_back(exp);
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_acc = acc; cmd_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      rdy = cmd_ready;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      tick();
      done = rdy;
    end
    check("push_accept", 32'(done), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic push_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s,
                            input logic acc);
    logic [9:0] e;
    e = model_rsp(a, b, s, acc, model_acc);
    model_acc = e[9:2];
    push_exp(a, b, s, acc, e);
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic       acc;
    logic [7:0] data;
    logic       carry;
    logic       divz;
  } vec_t;
  vec_t tbl[10];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] last_data;
    logic [7:0] exp_opa;
    tbl[0] = '{8'd200, 8'd100, 4'h0, 1'b0, 8'd44,  1'b1, 1'b0};
    tbl[1] = '{8'd200, 8'd100, 4'h1, 1'b0, 8'd100, 1'b0, 1'b0};
    tbl[2] = '{8'd37,  8'd0,   4'h3, 1'b0, 8'hFF,  1'b0, 1'b1};
    tbl[3] = '{8'd37,  8'd5,   4'h3, 1'b0, 8'd7,   1'b0, 1'b0};
    tbl[4] = '{8'd99,  8'd3,   4'h0, 1'b1, 8'd10,  1'b0, 1'b0};
    tbl[5] = '{8'hF0,  8'h3C,  4'h8, 1'b0, 8'h30,  1'b0, 1'b0};
    tbl[6] = '{8'h81,  8'h00,  4'h6, 1'b0, 8'h03,  1'b0, 1'b0};
    tbl[7] = '{8'd255, 8'd1,   4'h0, 1'b0, 8'd0,   1'b1, 1'b0};
    tbl[8] = '{8'h12,  8'd0,   4'h3, 1'b1, 8'hFF,  1'b0, 1'b1};
    tbl[9] = '{8'h55,  8'hFF,  4'h0, 1'b1, 8'hFE,  1'b1, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_acc = 1'b0;
    rsp_ready = 1'b0;
    model_acc = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_fifo_count", 32'(fifo_count), 32'd0);
    check("reset_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("reset_rsp", 32'({rsp_data, rsp_carry, rsp_divz}), 32'd0);

    // Single commands into an idle block: exact latency and captured values.
    rsp_ready = 1'b1;
    last_data = 8'd0;
    for (int i = 0; i < 10; i++) begin
      exp_opa = tbl[i].acc ? last_data : tbl[i].a;
      cmd_a = tbl[i].a; cmd_b = tbl[i].b; cmd_sel = tbl[i].sel; cmd_acc = tbl[i].acc;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("t0_valid", 32'(rsp_valid), 32'd0);
      check("t0_count", 32'(fifo_count), 32'd1);
      tick();
      check("t1_valid", 32'(rsp_valid), 32'd0);
      check("t1_count", 32'(fifo_count), 32'd0);
      check("t1_alu_ops", 32'({alu_a, alu_b, alu_sel}), 32'({exp_opa, tbl[i].b, tbl[i].sel}));
      tick();
      check("t2_valid", 32'(rsp_valid), 32'd1);
      check("t2_rsp", 32'({rsp_data, rsp_carry, rsp_divz}),
            32'({tbl[i].data, tbl[i].carry, tbl[i].divz}));
      tick();
      check("t3_valid", 32'(rsp_valid), 32'd0);
      last_data = tbl[i].data;
    end

    mon_en = 1'b1;

    // Accumulate chain queued back-to-back.
    push_exp(8'd10, 8'd5,  4'h0, 1'b0, {8'd15, 1'b0, 1'b0});
    push_exp(8'd77, 8'd3,  4'h2, 1'b1, {8'd45, 1'b0, 1'b0});
    push_exp(8'd0,  8'd1,  4'h4, 1'b1, {8'd90, 1'b0, 1'b0});
    push_exp(8'd3,  8'd90, 4'hF, 1'b1, {8'd1,  1'b0, 1'b0});
    model_acc = 8'd1;
    drain();

    // Back-pressure: fill the FIFO behind a stalled response, then release.
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push_model(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)),
                 4'($urandom_range(0, 15)), 1'b0);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_rsp_valid", 32'(rsp_valid), 32'd1);
    cmd_a = 8'd12; cmd_b = 8'd34; cmd_sel = 4'h9; cmd_acc = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("blocked_ready", 32'(cmd_ready), 32'd0);
      check("blocked_count", 32'(fifo_count), 32'd4);
    end
    rsp_ready = 1'b1;
    push_model(8'd12, 8'd34, 4'h9, 1'b0);
    drain();

    // Reset mid-stream: one response in RESP, three queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)), 1'b0);
    tick();
    rst = 1'b1;
    exp_q.delete();
    model_acc = 8'd0;
    repeat (2) tick();
    rst = 1'b0;
    check("mid_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_reset_count", 32'(fifo_count), 32'd0);
    check("mid_reset_ready", 32'(cmd_ready), 32'd1);
    check("mid_reset_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale_rsp", 32'(rsp_valid), 32'd0);
    end
    push_model(8'h99, 8'd5, 4'h0, 1'b1);
    drain();

    // Randomized traffic with random response back-pressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rsp_ready = 1'($urandom_range(0, 1));
        tick();
      end
      push_model(8'($urandom_range(0, 255)),
                 ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
